// File: rtl/hazard_ctrl_pkg.sv
// Shared stall codes, register widths and FSM state type
// for the hazard controller slice.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int STALL_WIDTH    = 1;

    typedef logic [STALL_WIDTH:0] stall_t;

    localparam stall_t STALL_NONE   = 2'd0;
    localparam stall_t STALL_LOAD   = 2'd1;
    localparam stall_t STALL_BRANCH = 2'd2;
    localparam stall_t STALL_MEM    = 2'd3;

    typedef enum logic {
        IDLE,
        FLUSH
    } hz_state_e;

    function automatic logic load_use_f(
        input logic                      mem_read,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic                      rs1_en,
        input logic [REG_ADDR_WIDTH-1:0] rs1,
        input logic                      rs2_en,
        input logic [REG_ADDR_WIDTH-1:0] rs2
    );
        return mem_read && (rd != '0) &&
               ((rs1_en && rs1 == rd) ||
                (rs2_en && rs2 == rd));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; clear has priority
// over increment.
module hazard_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall generator: load-use, branch flush,
// memory freeze, timeout flag and stall counters.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT         = 64,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rs1_rd_en_id,
    input  logic                      rs2_rd_en_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
    input  logic                      mem_read_ex,
    input  logic                      branch_taken_ex,
    input  logic                      mem_busy,
    input  logic                      cnt_clr,
    output logic [STALL_WIDTH:0]      stall,
    output logic                      mem_timeout,
    output logic [CNT_WIDTH-1:0]      stall_load_cnt,
    output logic [CNT_WIDTH-1:0]      stall_br_cnt,
    output logic [CNT_WIDTH-1:0]      stall_mem_cnt
);

    localparam int BW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] FLUSH_INIT =
        3'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [BW-1:0] BUSY_MAX = BW'(MEM_TIMEOUT);

    hz_state_e      state, state_nx;
    logic [2:0]     flush_cnt, flush_nx;
    logic [BW-1:0]  busy_cnt;
    logic           load_use;

    assign load_use = load_use_f(mem_read_ex, rd_addr_ex,
                                 rs1_rd_en_id, rs1_addr_id,
                                 rs2_rd_en_id, rs2_addr_id);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_nx;
        end
    end

    // mem_busy freezes the whole pipe, FSM included
    always_comb begin
        state_nx = state;
        flush_nx = flush_cnt;
        stall    = STALL_NONE;
        if (!rst) begin
            stall = STALL_NONE;
        end else if (mem_busy) begin
            stall = STALL_MEM;
        end else if (state == FLUSH) begin
            stall = STALL_BRANCH;
            if (flush_cnt <= 3'd1) begin
                state_nx = IDLE;
                flush_nx = '0;
            end else begin
                flush_nx = flush_cnt - 3'd1;
            end
        end else if (branch_taken_ex) begin
            stall = STALL_BRANCH;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_nx = FLUSH;
                flush_nx = FLUSH_INIT;
            end
        end else if (load_use) begin
            stall = STALL_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!mem_busy) begin
                busy_cnt <= '0;
            end else if (busy_cnt < BUSY_MAX) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
            if (mem_busy && busy_cnt >= BUSY_MAX - 1'b1) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    hazard_perf_cnt #(.W(CNT_WIDTH)) u_load_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall == STALL_LOAD),
        .clr (cnt_clr),
        .cnt (stall_load_cnt)
    );

    hazard_perf_cnt #(.W(CNT_WIDTH)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall == STALL_BRANCH),
        .clr (cnt_clr),
        .cnt (stall_br_cnt)
    );

    hazard_perf_cnt #(.W(CNT_WIDTH)) u_mem_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall == STALL_MEM),
        .clr (cnt_clr),
        .cnt (stall_mem_cnt)
    );

endmodule
